instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//   Fetch-side initiator for the synchronous instruction memory (word address in, data one clock later).
//   Drives the memory address each cycle and tracks which PC the returned word belongs to.
//   Presents a valid/stall stream of (instr, instr_pc) to decode, and supports branch/jump redirect.
//   Counts accepted instructions for performance readout.
// PARAMETERS
//   ADDR_WIDTH   16       word-address width; PC counts 32-bit words, +1 per instruction
//   DATA_WIDTH   32       instruction width
//   RESET_PC     16'h0000 first word fetched after reset
//   COUNT_WIDTH  32       width of fetch_count
// PORTS
//   clk          in   1           clock; all state on posedge
//   reset        in   1           asynchronous, active-high
//   imem_addr    out  ADDR_WIDTH  word address to instruction memory (combinational)
//   imem_rd      in   DATA_WIDTH  memory data: word at imem_addr from previous posedge
//   stall        in   1           decode cannot accept instr this cycle
//   redirect     in   1           branch/jump taken; discard current and in-flight work
//   redirect_pc  in   ADDR_WIDTH  new word PC, sampled when redirect=1
//   instr        out  DATA_WIDTH  instruction (= imem_rd, combinational)
//   instr_pc     out  ADDR_WIDTH  word PC of instr
//   instr_valid  out  1           instr/instr_pc meaningful this cycle
//   fetch_count  out  COUNT_WIDTH number of accepted instructions
// BEHAVIOUR
//   State: fetch_pc (next PC to request), resp_pc (PC whose word is on imem_rd), resp_valid, fetch_count.
//   Reset (async): fetch_pc=RESET_PC, resp_pc=RESET_PC, resp_valid=0, fetch_count=0.
//     Outputs during reset: instr_valid=0, instr_pc=RESET_PC, imem_addr=RESET_PC.
//   advance = !stall || !resp_valid (stall ignored when nothing valid is held).
//   accept  = instr_valid && !stall.
//   imem_addr (priority): redirect -> redirect_pc; advance -> fetch_pc; else resp_pc (replay).
//     Replay re-reads the held word, so imem_rd stays correct through any stall length.
//   instr_valid = resp_valid && !redirect; instr_pc = resp_pc; instr = imem_rd.
//   Posedge update (priority):
//     redirect: resp_pc<=redirect_pc, resp_valid<=1, fetch_pc<=redirect_pc+1.
//     advance:  resp_pc<=fetch_pc,    resp_valid<=1, fetch_pc<=fetch_pc+1.
//     else:     hold resp_pc, resp_valid, fetch_pc.
//   fetch_count += 1 on accept (never during a redirect cycle); wraps modulo 2^COUNT_WIDTH.
//   Latency: first instr_valid one cycle after reset release; redirect target valid the next cycle.
//   Redirect and stall together: redirect wins; stalled instruction is dropped, not counted.
//   PC arithmetic modulo 2^ADDR_WIDTH: 0xFFFF+1 = 0x0000, no error.
//   Redirect to the PC currently shown is legal: that word is reissued, shown once more.
//   Reset mid-stream: in-flight imem_rd discarded; fetch restarts at RESET_PC.
//   Sustained throughput: one instruction per cycle with stall=0, no bubbles except on redirect.
// TESTING
//   Memory model RAM[i]=32'hA000_0000+i, registered read, RESET_PC=0 unless noted.
//   1 Release reset, stall=0 -> instr_valid=1 from cycle 1; instr_pc 0,1,2,..; instr=RAM[pc];
//     fetch_count increments each cycle.
//   2 stall=1 for 3 cycles while instr_pc=5 -> instr_pc=5, instr=A000_0005, valid=1 held;
//     after release next is 6; no skip/duplicate; count +1 for pc 5.
//   3 redirect=1, redirect_pc=0x0100 while instr_pc=3 -> that cycle valid=0, pc 3 not counted;
//     next cycles instr_pc 0x0100, 0x0101 with matching data.
//   4 redirect=1 and stall=1 same cycle (redirect_pc=0x20) -> redirect wins;
//     next cycle instr_pc=0x20, valid=1.
//   5 redirect_pc=0xFFFE, stall=0 -> instr_pc FFFE, FFFF, 0000, 0001; data matches RAM.
//   6 Assert reset asynchronously mid-stream (between edges) -> instr_valid=0 and fetch_count=0
//     immediately; after release stream restarts at RESET_PC (rerun with RESET_PC=0x0040).

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch initiator for a synchronous instruction memory: one instr per cycle, first valid one cycle after reset.
// Stall holds the shown word by re-reading its address; a redirect drops the current word and restarts at redirect_pc.
module instruction_fetch #(
    parameter int unsigned           ADDR_WIDTH  = 16,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned           COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [DATA_WIDTH-1:0]  imem_rd,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic [DATA_WIDTH-1:0]  instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic                   instr_valid,
    output logic [COUNT_WIDTH-1:0] fetch_count
);
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] resp_pc;
    logic                  resp_valid;
    logic                  advance;
    logic                  accept;

    // With nothing held there is nothing to stall, so the pipe keeps filling.
    assign advance     = !stall || !resp_valid;
    assign instr_valid = resp_valid && !redirect;
    assign accept      = instr_valid && !stall;
    assign instr       = imem_rd;
    assign instr_pc    = resp_pc;

    always_comb begin
        imem_addr = resp_pc;
        if (redirect)
            imem_addr = redirect_pc;
        else if (advance)
            imem_addr = fetch_pc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            resp_valid  <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (redirect) begin
                resp_pc    <= redirect_pc;
                resp_valid <= 1'b1;
                fetch_pc   <= redirect_pc + ADDR_WIDTH'(1);
            end else if (advance) begin
                resp_pc    <= fetch_pc;
                resp_valid <= 1'b1;
                fetch_pc   <= fetch_pc + ADDR_WIDTH'(1);
            end
            if (accept)
                fetch_count <= fetch_count + COUNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench: two fetch units (RESET_PC 0 and 0x0040) share stimulus, each with its own registered-read memory.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;

    logic [15:0] addr0, pc0, addr1, pc1;
    logic [31:0] rd0, instr0, cnt0, rd1, instr1, cnt1;
    logic        vld0, vld1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(16'h0000)) dut0 (
        .clk(clk), .reset(reset), .imem_addr(addr0), .imem_rd(rd0),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr(instr0), .instr_pc(pc0), .instr_valid(vld0), .fetch_count(cnt0)
    );

    instruction_fetch #(.RESET_PC(16'h0040)) dut1 (
        .clk(clk), .reset(reset), .imem_addr(addr1), .imem_rd(rd1),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr(instr1), .instr_pc(pc1), .instr_valid(vld1), .fetch_count(cnt1)
    );

    // RAM[i] = A000_0000 + i with one-cycle registered read
    always @(posedge clk) begin
        rd0 <= 32'hA000_0000 + {16'h0000, addr0};
        rd1 <= 32'hA000_0000 + {16'h0000, addr1};
    end

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (vld0 !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", vld0); end
        tests++; if (pc0 !== 16'h0000) begin fails++; $display("FAIL reset_pc got %h want 0000", pc0); end
        tests++; if (addr0 !== 16'h0000) begin fails++; $display("FAIL reset_addr got %h want 0000", addr0); end
        tests++; if (cnt0 !== 32'd0) begin fails++; $display("FAIL reset_count got %0d want 0", cnt0); end
        tests++; if (pc1 !== 16'h0040 || addr1 !== 16'h0040 || vld1 !== 1'b0) begin
            fails++; $display("FAIL reset_pc40 got pc=%h addr=%h vld=%0b want 0040/0040/0", pc1, addr1, vld1);
        end
    endtask

    // Stream pc 0..4 after release, one per cycle, count tracking pc
    task automatic test_stream();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            tests++;
            if (vld0 !== 1'b1 || pc0 !== 16'(i) || instr0 !== 32'hA000_0000 + i || cnt0 !== 32'(i)) begin
                fails++;
                $display("FAIL stream[%0d] got vld=%0b pc=%h instr=%h cnt=%0d want 1/%h/%h/%0d",
                         i, vld0, pc0, instr0, cnt0, 16'(i), 32'hA000_0000 + i, i);
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            stall = (i < 3);
            #1;
            tests++;
            if (vld0 !== 1'b1 || pc0 !== 16'h0005 || instr0 !== 32'hA000_0005 || cnt0 !== 32'd5) begin
                fails++;
                $display("FAIL stall[%0d] got vld=%0b pc=%h instr=%h cnt=%0d want 1/0005/a0000005/5",
                         i, vld0, pc0, instr0, cnt0);
            end
            if (i < 3) begin
                tests++;
                if (addr0 !== 16'h0005) begin fails++; $display("FAIL stall_replay_addr got %h want 0005", addr0); end
            end
        end
        for (int i = 6; i < 8; i++) begin
            @(negedge clk); #1;
            tests++;
            if (pc0 !== 16'(i) || instr0 !== 32'hA000_0000 + i || cnt0 !== 32'(i)) begin
                fails++;
                $display("FAIL after_stall got pc=%h instr=%h cnt=%0d want %h/%h/%0d", pc0, instr0, cnt0, 16'(i),
                         32'hA000_0000 + i, i);
            end
        end
    endtask

    task automatic test_redirect();
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'h0100;
        #1;
        tests++;
        if (vld0 !== 1'b0 || addr0 !== 16'h0100 || pc0 !== 16'h0008) begin
            fails++; $display("FAIL redirect_cycle got vld=%0b addr=%h pc=%h want 0/0100/0008", vld0, addr0, pc0);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            redirect = 1'b0;
            #1;
            tests++;
            if (vld0 !== 1'b1 || pc0 !== 16'h0100 + 16'(i) || instr0 !== 32'hA000_0100 + i || cnt0 !== 32'd8 + i) begin
                fails++;
                $display("FAIL redirect_target[%0d] got vld=%0b pc=%h instr=%h cnt=%0d want 1/%h/%h/%0d", i, vld0,
                         pc0, instr0, cnt0, 16'h0100 + 16'(i), 32'hA000_0100 + i, 8 + i);
            end
        end
    endtask

    task automatic test_redirect_stall();
        @(negedge clk);
        redirect = 1'b1; stall = 1'b1; redirect_pc = 16'h0020;
        #1;
        tests++;
        if (vld0 !== 1'b0 || pc0 !== 16'h0102 || cnt0 !== 32'd10) begin
            fails++; $display("FAIL redir_stall_cycle got vld=%0b pc=%h cnt=%0d want 0/0102/10", vld0, pc0, cnt0);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            redirect = 1'b0; stall = 1'b0;
            #1;
            tests++;
            if (vld0 !== 1'b1 || pc0 !== 16'h0020 + 16'(i) || instr0 !== 32'hA000_0020 + i || cnt0 !== 32'd10 + i) begin
                fails++;
                $display("FAIL redir_stall_target[%0d] got vld=%0b pc=%h instr=%h cnt=%0d want 1/%h/%h/%0d", i, vld0,
                         pc0, instr0, cnt0, 16'h0020 + 16'(i), 32'hA000_0020 + i, 10 + i);
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pc;
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        #1;
        tests++;
        if (vld0 !== 1'b0 || pc0 !== 16'h0022) begin
            fails++; $display("FAIL wrap_redirect got vld=%0b pc=%h want 0/0022", vld0, pc0);
        end
        exp_pc = 16'hFFFE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            redirect = 1'b0;
            #1;
            tests++;
            if (vld0 !== 1'b1 || pc0 !== exp_pc || instr0 !== 32'hA000_0000 + {16'h0000, exp_pc} || cnt0 !== 32'd12 + i) begin
                fails++;
                $display("FAIL wrap[%0d] got vld=%0b pc=%h instr=%h cnt=%0d want 1/%h/%h/%0d", i, vld0, pc0, instr0,
                         cnt0, exp_pc, 32'hA000_0000 + {16'h0000, exp_pc}, 12 + i);
            end
            exp_pc = exp_pc + 16'h0001;
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (vld0 !== 1'b0 || cnt0 !== 32'd0 || pc0 !== 16'h0000) begin
            fails++; $display("FAIL async_reset0 got vld=%0b cnt=%0d pc=%h want 0/0/0000", vld0, cnt0, pc0);
        end
        tests++;
        if (vld1 !== 1'b0 || cnt1 !== 32'd0 || pc1 !== 16'h0040) begin
            fails++; $display("FAIL async_reset1 got vld=%0b cnt=%0d pc=%h want 0/0/0040", vld1, cnt1, pc1);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            tests++;
            if (vld0 !== 1'b1 || pc0 !== 16'(i) || instr0 !== 32'hA000_0000 + i || cnt0 !== 32'(i)) begin
                fails++;
                $display("FAIL restart0[%0d] got vld=%0b pc=%h instr=%h cnt=%0d want 1/%h/%h/%0d", i, vld0, pc0,
                         instr0, cnt0, 16'(i), 32'hA000_0000 + i, i);
            end
            tests++;
            if (vld1 !== 1'b1 || pc1 !== 16'h0040 + 16'(i) || instr1 !== 32'hA000_0040 + i || cnt1 !== 32'(i)) begin
                fails++;
                $display("FAIL restart40[%0d] got vld=%0b pc=%h instr=%h cnt=%0d want 1/%h/%h/%0d", i, vld1, pc1,
                         instr1, cnt1, 16'h0040 + 16'(i), 32'hA000_0040 + i, i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
